// File: rtl/counter_pkg.sv
// Shared constants and helpers for the cascaded modulo-N counter family.
package counter_pkg;

  localparam int DIGIT_W_DEFAULT = 4;
  localparam int MOD_DEC         = 10;

  // Smallest r such that 2**r >= v; used to check that a digit can hold MOD-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_n_digit.sv
// One modulo-MOD digit: sync reset, clamped parallel load, up/down step with wrap pulse.
import counter_pkg::*;

module mod_n_digit #(
  parameter int MOD = MOD_DEC,
  parameter int DW  = DIGIT_W_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  input  logic          up,
  input  logic          load,
  input  logic [DW-1:0] ld_val,
  output logic [DW-1:0] q,
  output logic          at_max,
  output logic          at_min,
  output logic          wrap
);

  localparam logic [DW-1:0] MAX_V = DW'(MOD - 1);

  logic [DW-1:0] ld_clamped;

  assign at_max     = (q == MAX_V);
  assign at_min     = (q == '0);
  assign ld_clamped = (ld_val > MAX_V) ? MAX_V : ld_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= ld_clamped;
      wrap <= 1'b0;
    end else if (step) begin
      if (up) begin
        if (at_max) begin
          q    <= '0;
          wrap <= 1'b1;
        end else begin
          q    <= q + 1'b1;
          wrap <= 1'b0;
        end
      end else begin
        if (at_min) begin
          q    <= MAX_V;
          wrap <= 1'b1;
        end else begin
          q    <= q - 1'b1;
          wrap <= 1'b0;
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/mod_n_cascade_counter.sv
// Multi-digit modulo-N up/down counter; single-cycle carry/borrow chain across digits.
import counter_pkg::*;

module mod_n_cascade_counter #(
  parameter int DIGITS = 4,
  parameter int MOD    = MOD_DEC,
  parameter int DW     = DIGIT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 up,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] q,
  output logic [DIGITS-1:0]    wrap,
  output logic                 z
);

  if (DIGITS < 1 || DIGITS > 8 || MOD < 2 || clog2(MOD) > DW) begin : g_param_check
    $error("mod_n_cascade_counter: illegal DIGITS/MOD/DW combination");
  end

  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic              acc_max;
  logic              acc_min;

  // Digit i steps when every lower digit sits at its terminal value for the current direction.
  always_comb begin
    step    = '0;
    acc_max = 1'b1;
    acc_min = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      step[i] = en & (up ? acc_max : acc_min);
      acc_max = acc_max & at_max[i];
      acc_min = acc_min & at_min[i];
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    mod_n_digit #(
      .MOD (MOD),
      .DW  (DW)
    ) u_digit (
      .clk    (clk),
      .reset  (reset),
      .step   (step[i]),
      .up     (up),
      .load   (load),
      .ld_val (load_val[i*DW +: DW]),
      .q      (q[i*DW +: DW]),
      .at_max (at_max[i]),
      .at_min (at_min[i]),
      .wrap   (wrap[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset || load) begin
      z <= 1'b0;
    end else begin
      z <= step[DIGITS-1] & (up ? at_max[DIGITS-1] : at_min[DIGITS-1]);
    end
  end

endmodule

// File: tb/tb_mod_n_cascade_counter.sv
// Directed vector bench for mod_n_cascade_counter (3x decimal, plus 2x mod-6 variant).
module tb_mod_n_cascade_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset = 1'b1, a_en = 1'b0, a_up = 1'b0, a_load = 1'b0;
  logic [11:0] a_load_val = '0;
  logic [11:0] a_q;
  logic [2:0]  a_wrap;
  logic        a_z;

  logic        b_reset = 1'b1, b_en = 1'b0, b_up = 1'b0, b_load = 1'b0;
  logic [5:0]  b_load_val = '0;
  logic [5:0]  b_q;
  logic [1:0]  b_wrap;
  logic        b_z;

  mod_n_cascade_counter #(.DIGITS(3), .MOD(10), .DW(4)) dut_a (
    .clk(clk), .reset(a_reset), .en(a_en), .up(a_up), .load(a_load),
    .load_val(a_load_val), .q(a_q), .wrap(a_wrap), .z(a_z)
  );

  mod_n_cascade_counter #(.DIGITS(2), .MOD(6), .DW(3)) dut_b (
    .clk(clk), .reset(b_reset), .en(b_en), .up(b_up), .load(b_load),
    .load_val(b_load_val), .q(b_q), .wrap(b_wrap), .z(b_z)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic        ld;
    logic        en;
    logic        up;
    logic [11:0] lv;
    logic [11:0] eq;
    logic [2:0]  ew;
    logic        ez;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic r, logic l, logic e, logic u, logic [11:0] lv,
                              logic [11:0] eq, logic [2:0] ew, logic ez);
    vec_t v;
    v.rst = r; v.ld = l; v.en = e; v.up = u; v.lv = lv; v.eq = eq; v.ew = ew; v.ez = ez;
    return v;
  endfunction

  function automatic logic [11:0] bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic r, input logic l, input logic e, input logic u,
                         input logic [11:0] lv);
    @(negedge clk);
    a_reset = r; a_load = l; a_en = e; a_up = u; a_load_val = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic r, input logic l, input logic e, input logic u,
                         input logic [5:0] lv);
    @(negedge clk);
    b_reset = r; b_load = l; b_en = e; b_up = u; b_load_val = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [11:0] eq, input logic [2:0] ew,
                       input logic ez);
    chk({tag, ".q"}, 32'(a_q), 32'(eq));
    chk({tag, ".wrap"}, 32'(a_wrap), 32'(ew));
    chk({tag, ".z"}, 32'(a_z), 32'(ez));
  endtask

  task automatic chk_b(input string tag, input logic [5:0] eq, input logic [1:0] ew,
                       input logic ez);
    chk({tag, ".q"}, 32'(b_q), 32'(eq));
    chk({tag, ".wrap"}, 32'(b_wrap), 32'(ew));
    chk({tag, ".z"}, 32'(b_z), 32'(ez));
  endtask

  initial begin
    int z_cnt, w0_cnt, w1_cnt;

    //             rst   ld    en    up    load_val  exp_q    exp_w   exp_z
    vecs[0]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 12'h000, 12'h000, 3'b000, 1'b0);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 12'h099, 12'h099, 3'b000, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h100, 3'b011, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 12'h100, 3'b000, 1'b0);
    vecs[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 3'b000, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h999, 3'b111, 1'b1);
    vecs[6]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h998, 3'b000, 1'b0);
    vecs[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 12'hFA3, 12'h993, 3'b000, 1'b0);
    vecs[8]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 12'h123, 12'h123, 3'b000, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h124, 3'b000, 1'b0);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 12'h457, 12'h457, 3'b000, 1'b0);
    vecs[11] = mk(1'b1, 1'b1, 1'b1, 1'b1, 12'h999, 12'h000, 3'b000, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h001, 3'b000, 1'b0);
    vecs[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, 12'h999, 12'h999, 3'b000, 1'b0);
    vecs[14] = mk(1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h000, 3'b111, 1'b1);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 12'h000, 3'b000, 1'b0);
    vecs[16] = mk(1'b0, 1'b1, 1'b0, 1'b0, 12'h0F0, 12'h090, 3'b000, 1'b0);
    vecs[17] = mk(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h089, 3'b001, 1'b0);
    vecs[18] = mk(1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h090, 3'b001, 1'b0);
    vecs[19] = mk(1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h091, 3'b000, 1'b0);
    vecs[20] = mk(1'b1, 1'b0, 1'b1, 1'b1, 12'h000, 12'h000, 3'b000, 1'b0);

    // Full walk: two reset cycles, then 1000 up steps back to 000.
    drive_a(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    drive_a(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    chk_a("reset", 12'h000, 3'b000, 1'b0);
    z_cnt = 0; w0_cnt = 0; w1_cnt = 0;
    for (int c = 1; c <= 1000; c++) begin
      int n;
      n = c % 1000;
      drive_a(1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
      chk_a("walk", bcd(n), {n % 1000 == 0, n % 100 == 0, n % 10 == 0}, n == 0);
      if (a_z) z_cnt++;
      if (a_wrap[0]) w0_cnt++;
      if (a_wrap[1]) w1_cnt++;
    end
    chk("walk.z_count", 32'(z_cnt), 32'd1);
    chk("walk.wrap0_count", 32'(w0_cnt), 32'd100);
    chk("walk.wrap1_count", 32'(w1_cnt), 32'd10);

    for (int i = 0; i < 21; i++) begin
      drive_a(vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].lv);
      chk_a($sformatf("vec%0d", i), vecs[i].eq, vecs[i].ew, vecs[i].ez);
    end

    // Two-digit mod-6 instance: top wrap, clamp, and direction alternation.
    drive_b(1'b1, 1'b0, 1'b0, 1'b0, 6'o00);
    chk_b("b_reset", 6'o00, 2'b00, 1'b0);
    drive_b(1'b0, 1'b1, 1'b0, 1'b0, 6'o55);
    chk_b("b_load55", 6'o55, 2'b00, 1'b0);
    drive_b(1'b0, 1'b0, 1'b1, 1'b1, 6'o00);
    chk_b("b_up55", 6'o00, 2'b11, 1'b1);
    drive_b(1'b0, 1'b1, 1'b0, 1'b0, 6'o77);
    chk_b("b_clamp", 6'o55, 2'b00, 1'b0);
    drive_b(1'b0, 1'b1, 1'b0, 1'b0, 6'o05);
    chk_b("b_load05", 6'o05, 2'b00, 1'b0);
    drive_b(1'b0, 1'b0, 1'b1, 1'b1, 6'o00);
    chk_b("b_alt_up1", 6'o10, 2'b01, 1'b0);
    drive_b(1'b0, 1'b0, 1'b1, 1'b0, 6'o00);
    chk_b("b_alt_dn", 6'o05, 2'b01, 1'b0);
    drive_b(1'b0, 1'b0, 1'b1, 1'b1, 6'o00);
    chk_b("b_alt_up2", 6'o10, 2'b01, 1'b0);
    drive_b(1'b0, 1'b0, 1'b0, 1'b0, 6'o00);
    chk_b("b_hold", 6'o10, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
